// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller for a 5-stage RISC-V core: load-use bubbles,
// taken-branch flushes and a watchdog-guarded freeze for multi-cycle MDU ops.
module hazard_stall_ctrl #(
   parameter int MDU_TIMEOUT = 64,
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [4:0]             id_rs1,
   input  logic [4:0]             id_rs2,
   input  logic                   id_uses_rs1,
   input  logic                   id_uses_rs2,
   input  logic                   id_ex_memread,
   input  logic [4:0]             id_ex_rd,
   input  logic                   branch_taken,
   input  logic                   ex_is_mdu,
   input  logic                   mdu_done,
   output logic                   pc_write,
   output logic                   if_id_write,
   output logic                   if_id_flush,
   output logic                   id_ex_flush,
   output logic                   ex_hold,
   output logic                   ex_mem_bubble,
   output logic                   mdu_timeout,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam int WD_W = $clog2(MDU_TIMEOUT + 1);

   typedef enum logic {ST_RUN, ST_MDU_WAIT} state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [WD_W-1:0]        r_wd_cnt;
   logic [WD_W-1:0]        w_wd_next;
   logic                   r_mdu_timeout;
   logic                   w_set_timeout;
   logic                   w_load_use;
   logic                   w_rs1_hit;
   logic                   w_rs2_hit;
   logic [STALL_CNT_W-1:0] r_stall_cycles;

   assign w_rs1_hit  = id_uses_rs1 && (id_rs1 == id_ex_rd);
   assign w_rs2_hit  = id_uses_rs2 && (id_rs2 == id_ex_rd);
   assign w_load_use = id_ex_memread && (id_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

   // Outputs are decoded from the registered state and live inputs so that
   // stalls and flushes act in the same cycle the hazard is seen.
   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_hold       = 1'b0;
      ex_mem_bubble = 1'b0;
      w_next_state  = r_state;
      w_wd_next     = r_wd_cnt;
      w_set_timeout = 1'b0;
      if (rst_n) begin
         case (r_state)
            ST_RUN: begin
               if (ex_is_mdu && !mdu_done) begin
                  pc_write      = 1'b0;
                  if_id_write   = 1'b0;
                  ex_hold       = 1'b1;
                  ex_mem_bubble = 1'b1;
                  w_next_state  = ST_MDU_WAIT;
                  w_wd_next     = WD_W'(1);
               end else if (branch_taken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (w_load_use) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
            ST_MDU_WAIT: begin
               if (mdu_done) begin
                  w_next_state = ST_RUN;
                  w_wd_next    = '0;
               end else if (r_wd_cnt == WD_W'(MDU_TIMEOUT)) begin
                  // Watchdog: drop the stuck MDU op by bubbling EX/MEM and resume fetch.
                  ex_mem_bubble = 1'b1;
                  w_set_timeout = 1'b1;
                  w_next_state  = ST_RUN;
                  w_wd_next     = '0;
               end else begin
                  pc_write      = 1'b0;
                  if_id_write   = 1'b0;
                  ex_hold       = 1'b1;
                  ex_mem_bubble = 1'b1;
                  w_wd_next     = r_wd_cnt + WD_W'(1);
               end
            end
            default: begin
               w_next_state = ST_RUN;
               w_wd_next    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= ST_RUN;
         r_wd_cnt       <= '0;
         r_mdu_timeout  <= 1'b0;
         r_stall_cycles <= '0;
      end else begin
         r_state  <= w_next_state;
         r_wd_cnt <= w_wd_next;
         if (w_set_timeout) begin
            r_mdu_timeout <= 1'b1;
         end
         if (!pc_write && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
         end
      end
   end

   assign mdu_timeout  = r_mdu_timeout;
   assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (default and a short watchdog /
// 4-bit counter variant) share stimulus and are checked against a cycle model.
module tb_hazard_stall_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, id_ex_rd;
   logic       id_uses_rs1, id_uses_rs2, id_ex_memread;
   logic       branch_taken, ex_is_mdu, mdu_done;

   logic        a_pc, a_ifid, a_iff, a_idf, a_hold, a_bub, a_to;
   logic [31:0] a_stall;
   logic        b_pc, b_ifid, b_iff, b_idf, b_hold, b_bub, b_to;
   logic [3:0]  b_stall;

   logic [5:0]  act_ctrl  [2];
   logic [63:0] act_stall [2];
   logic        act_to    [2];

   // Reference model state: whether an MDU freeze is in progress, how many
   // cycles it has lasted, the sticky error and the saturating stall count.
   logic        m_busy   [2];
   int          m_held   [2];
   logic        m_to     [2];
   logic [63:0] m_stalls [2];

   int total;
   int bad;

   hazard_stall_ctrl dut_a (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
      .branch_taken(branch_taken), .ex_is_mdu(ex_is_mdu), .mdu_done(mdu_done),
      .pc_write(a_pc), .if_id_write(a_ifid), .if_id_flush(a_iff),
      .id_ex_flush(a_idf), .ex_hold(a_hold), .ex_mem_bubble(a_bub),
      .mdu_timeout(a_to), .stall_cycles(a_stall)
   );

   hazard_stall_ctrl #(.MDU_TIMEOUT(4), .STALL_CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
      .branch_taken(branch_taken), .ex_is_mdu(ex_is_mdu), .mdu_done(mdu_done),
      .pc_write(b_pc), .if_id_write(b_ifid), .if_id_flush(b_iff),
      .id_ex_flush(b_idf), .ex_hold(b_hold), .ex_mem_bubble(b_bub),
      .mdu_timeout(b_to), .stall_cycles(b_stall)
   );

   assign act_ctrl[0]  = {a_pc, a_ifid, a_iff, a_idf, a_hold, a_bub};
   assign act_ctrl[1]  = {b_pc, b_ifid, b_iff, b_idf, b_hold, b_bub};
   assign act_stall[0] = {32'd0, a_stall};
   assign act_stall[1] = {60'd0, b_stall};
   assign act_to[0]    = a_to;
   assign act_to[1]    = b_to;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int timeout_of(int k);
      return (k == 0) ? 64 : 4;
   endfunction

   function automatic logic [63:0] stall_max(int k);
      return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd15;
   endfunction

   function automatic logic load_use_ref();
      logic dep;
      dep = (id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd);
      return id_ex_memread && (id_ex_rd != 5'd0) && dep;
   endfunction

   // Expected {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, ex_mem_bubble}.
   function automatic logic [5:0] model_ctrl(int k);
      if (!rst_n) return 6'b110000;
      if (m_busy[k]) begin
         if (mdu_done) return 6'b110000;
         if (m_held[k] == timeout_of(k)) return 6'b110001;
         return 6'b000011;
      end
      if (ex_is_mdu && !mdu_done) return 6'b000011;
      if (branch_taken) return 6'b111100;
      if (load_use_ref()) return 6'b000100;
      return 6'b110000;
   endfunction

   task automatic model_advance();
      logic [5:0] c;
      for (int k = 0; k < 2; k++) begin
         c = model_ctrl(k);
         if (!rst_n) begin
            m_busy[k] = 1'b0; m_held[k] = 0; m_to[k] = 1'b0; m_stalls[k] = 64'd0;
         end else begin
            if (!c[5] && m_stalls[k] < stall_max(k)) m_stalls[k] = m_stalls[k] + 64'd1;
            if (m_busy[k]) begin
               if (mdu_done) m_busy[k] = 1'b0;
               else if (m_held[k] == timeout_of(k)) begin
                  m_to[k] = 1'b1; m_busy[k] = 1'b0;
               end else m_held[k] = m_held[k] + 1;
            end else if (ex_is_mdu && !mdu_done) begin
               m_busy[k] = 1'b1; m_held[k] = 1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic idle_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      id_ex_memread = 1'b0; id_ex_rd = 5'd0;
      branch_taken = 1'b0; ex_is_mdu = 1'b0; mdu_done = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      id_ex_memread = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
      branch_taken = 1'b1; ex_is_mdu = 1'b1; mdu_done = 1'b0;
      #2;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (act_ctrl[k] !== 6'b110000) begin
            bad++; $display("FAIL reset_outputs[%0d] got=%b exp=%b", k, act_ctrl[k], 6'b110000);
         end
      end
      tick();
      tick();
      for (int k = 0; k < 2; k++) begin
         total++;
         if (act_stall[k] !== 64'd0 || act_to[k] !== 1'b0) begin
            bad++; $display("FAIL reset_regs[%0d] stall=%0d to=%b exp 0/0", k, act_stall[k], act_to[k]);
         end
      end
      idle_inputs();
      rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      logic [31:0] base;
      do_reset();
      base = a_stall;
      id_ex_memread = 1'b1; id_ex_rd = 5'd5;
      id_rs1 = 5'd5; id_uses_rs1 = 1'b1; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
      #2;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (act_ctrl[k] !== 6'b000100) begin
            bad++; $display("FAIL load_use_stall[%0d] got=%b exp=%b", k, act_ctrl[k], 6'b000100);
         end
      end
      tick();
      id_ex_memread = 1'b0;
      #2;
      total++;
      if (act_ctrl[0] !== 6'b110000) begin
         bad++; $display("FAIL load_use_release got=%b exp=%b", act_ctrl[0], 6'b110000);
      end
      total++;
      if (a_stall - base !== 32'd1) begin
         bad++; $display("FAIL load_use_count got=%0d exp=1", a_stall - base);
      end
      tick();
   endtask

   task automatic test_x0();
      logic [31:0] base;
      base = a_stall;
      id_ex_memread = 1'b1; id_ex_rd = 5'd0;
      id_rs1 = 5'd0; id_uses_rs1 = 1'b1; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
      #2;
      total++;
      if (act_ctrl[0] !== 6'b110000) begin
         bad++; $display("FAIL x0_no_stall got=%b exp=%b", act_ctrl[0], 6'b110000);
      end
      tick();
      total++;
      if (a_stall !== base) begin
         bad++; $display("FAIL x0_count got=%0d exp=%0d", a_stall, base);
      end
      idle_inputs();
   endtask

   task automatic test_branch_over_load_use();
      logic [31:0] base;
      base = a_stall;
      id_ex_memread = 1'b1; id_ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
      branch_taken = 1'b1;
      #2;
      total++;
      if (act_ctrl[0] !== 6'b111100) begin
         bad++; $display("FAIL branch_flush got=%b exp=%b", act_ctrl[0], 6'b111100);
      end
      tick();
      total++;
      if (a_stall !== base) begin
         bad++; $display("FAIL branch_count got=%0d exp=%0d", a_stall, base);
      end
      idle_inputs();
   endtask

   task automatic test_mdu_wait();
      logic [31:0] base;
      do_reset();
      base = a_stall;
      ex_is_mdu = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #2;
         total++;
         if (act_ctrl[0] !== 6'b000011) begin
            bad++; $display("FAIL mdu_hold cyc%0d got=%b exp=%b", i, act_ctrl[0], 6'b000011);
         end
         tick();
      end
      mdu_done = 1'b1;
      #2;
      total++;
      if (act_ctrl[0] !== 6'b110000) begin
         bad++; $display("FAIL mdu_release got=%b exp=%b", act_ctrl[0], 6'b110000);
      end
      tick();
      idle_inputs();
      #2;
      total++;
      if (a_stall - base !== 32'd5) begin
         bad++; $display("FAIL mdu_count got=%0d exp=5", a_stall - base);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      ex_is_mdu = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      #2;
      total++;
      if (act_ctrl[1] !== 6'b110001 || b_to !== 1'b0) begin
         bad++; $display("FAIL wd_fire got=%b to=%b exp=%b to=0", act_ctrl[1], b_to, 6'b110001);
      end
      tick();
      ex_is_mdu = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      #2;
      total++;
      if (b_to !== 1'b1 || act_ctrl[1] !== 6'b110000 || b_stall !== 4'd4) begin
         bad++; $display("FAIL wd_sticky to=%b ctrl=%b stall=%0d exp 1/110000/4", b_to, act_ctrl[1], b_stall);
      end
      // Completion in the watchdog cycle must win over the timeout.
      do_reset();
      ex_is_mdu = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      mdu_done = 1'b1;
      #2;
      total++;
      if (act_ctrl[1] !== 6'b110000) begin
         bad++; $display("FAIL wd_done_wins got=%b exp=%b", act_ctrl[1], 6'b110000);
      end
      tick();
      idle_inputs();
      #2;
      total++;
      if (b_to !== 1'b0) begin
         bad++; $display("FAIL wd_done_no_flag got=%b exp=0", b_to);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      ex_is_mdu = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      rst_n = 1'b0;
      #2;
      total++;
      if (act_ctrl[0] !== 6'b110000) begin
         bad++; $display("FAIL rst_wait_release got=%b exp=%b", act_ctrl[0], 6'b110000);
      end
      tick();
      rst_n = 1'b1;
      ex_is_mdu = 1'b0;
      #2;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (act_ctrl[k][5] !== 1'b1 || act_stall[k] !== 64'd0 || act_to[k] !== 1'b0) begin
            bad++; $display("FAIL rst_wait_after[%0d] pc=%b stall=%0d to=%b exp 1/0/0",
                            k, act_ctrl[k][5], act_stall[k], act_to[k]);
         end
      end
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      id_ex_memread = 1'b1; id_ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      #2;
      total++;
      if (b_stall !== 4'hF) begin
         bad++; $display("FAIL stall_saturate got=%0d exp=15", b_stall);
      end
      total++;
      if (a_stall !== 32'd20) begin
         bad++; $display("FAIL stall_count20 got=%0d exp=20", a_stall);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         rst_n         = ($urandom_range(0, 79) != 0);
         id_rs1        = 5'($urandom_range(0, 3));
         id_rs2        = 5'($urandom_range(0, 3));
         id_uses_rs1   = 1'($urandom_range(0, 1));
         id_uses_rs2   = 1'($urandom_range(0, 1));
         id_ex_memread = ($urandom_range(0, 2) == 0);
         id_ex_rd      = 5'($urandom_range(0, 3));
         branch_taken  = ($urandom_range(0, 5) == 0);
         ex_is_mdu     = ($urandom_range(0, 3) == 0);
         mdu_done      = ($urandom_range(0, (n < 300) ? 3 : 9) == 0);
         #2;
         for (int k = 0; k < 2; k++) begin
            total++;
            if (act_ctrl[k] !== model_ctrl(k)) begin
               bad++; $display("FAIL rand_ctrl[%0d] n=%0d got=%b exp=%b", k, n, act_ctrl[k], model_ctrl(k));
            end
            total++;
            if (act_stall[k] !== m_stalls[k] || act_to[k] !== m_to[k]) begin
               bad++; $display("FAIL rand_regs[%0d] n=%0d stall=%0d/%0d to=%b/%b",
                               k, n, act_stall[k], m_stalls[k], act_to[k], m_to[k]);
            end
         end
         tick();
      end
      idle_inputs();
      rst_n = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 1'b0; m_held[k] = 0; m_to[k] = 1'b0; m_stalls[k] = 64'd0;
      end
      idle_inputs();
      rst_n = 1'b0;
      #1;
      test_reset();
      test_load_use();
      test_x0();
      test_branch_over_load_use();
      test_mdu_wait();
      test_timeout();
      test_reset_mid_wait();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
